// File: rtl/sobel_column_engine.sv
// rtl/sobel_column_engine.sv - streaming 3x3 Sobel over columns, three magnitudes packed per word
// Build option: define SOBEL_THRESHOLD_EN to binarise each magnitude against THRESHOLD.
module sobel_column_engine #(
  parameter int PIXEL_W   = 8,
  parameter int WORD_W    = 3 * PIXEL_W,
  parameter int THRESHOLD = 128
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic [WORD_W-1:0] px_gray_i,
  input  logic              px_rdy_i,
  input  logic              clear_i,
  output logic [WORD_W-1:0] px_sobel_o,
  output logic              px_rdy_o
);

  localparam int SW = PIXEL_W + 3;

  typedef logic [PIXEL_W-1:0] pix_t;

  function automatic pix_t top_of(input logic [WORD_W-1:0] col);
    return col[WORD_W-1 -: PIXEL_W];
  endfunction

  function automatic pix_t mid_of(input logic [WORD_W-1:0] col);
    return col[2*PIXEL_W-1 -: PIXEL_W];
  endfunction

  function automatic pix_t bot_of(input logic [WORD_W-1:0] col);
    return col[PIXEL_W-1:0];
  endfunction

  function automatic logic signed [SW-1:0] wsum(input pix_t a, input pix_t m, input pix_t b);
    return $signed({3'b000, a} + {2'b00, m, 1'b0} + {3'b000, b});
  endfunction

  function automatic logic [SW-1:0] abs_s(input logic signed [SW-1:0] v);
    return v[SW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // The oldest column of the post-shift window is the current c1, so c0 needs no register.
  logic [WORD_W-1:0]    c1, c2;
  logic [1:0]           col_cnt;
  logic [1:0]           res_cnt;
  logic                 s1_valid, s2_valid;
  logic signed [SW-1:0] gx_q, gy_q;
  logic [PIXEL_W-1:0]   s2_res;
  logic [WORD_W-1:0]    pack;

  logic                 launch;
  logic signed [SW-1:0] gx_d, gy_d;
  logic [SW-1:0]        mag;
  logic [PIXEL_W-1:0]   res_d;

  assign launch = px_rdy_i & ~clear_i & (col_cnt >= 2'd2);

  assign gx_d = wsum(top_of(px_gray_i), mid_of(px_gray_i), bot_of(px_gray_i))
              - wsum(top_of(c1), mid_of(c1), bot_of(c1));
  assign gy_d = wsum(bot_of(c1), bot_of(c2), bot_of(px_gray_i))
              - wsum(top_of(c1), top_of(c2), top_of(px_gray_i));

  assign mag = abs_s(gx_q) + abs_s(gy_q);

`ifdef SOBEL_THRESHOLD_EN
  localparam logic [31:0] THR = THRESHOLD;
  assign res_d = (32'(mag) >= THR) ? '1 : '0;
`else
  logic [31:0] threshold_unused;
  assign threshold_unused = THRESHOLD;
  assign res_d = (mag > SW'({PIXEL_W{1'b1}})) ? '1 : mag[PIXEL_W-1:0];
`endif

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      c1         <= '0;
      c2         <= '0;
      col_cnt    <= '0;
      res_cnt    <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      s2_res     <= '0;
      pack       <= '0;
      px_sobel_o <= '0;
      px_rdy_o   <= 1'b0;
    end else begin
      px_rdy_o <= 1'b0;
      if (px_rdy_i) begin
        c1 <= c2;
        c2 <= px_gray_i;
      end
      if (clear_i) begin
        col_cnt  <= px_rdy_i ? 2'd1 : 2'd0;
        res_cnt  <= '0;
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (px_rdy_i && col_cnt != 2'd3) col_cnt <= col_cnt + 2'd1;
        s1_valid <= launch;
        if (launch) begin
          gx_q <= gx_d;
          gy_q <= gy_d;
        end
        s2_valid <= s1_valid;
        if (s1_valid) s2_res <= res_d;
        // A full word drains in the same cycle the next result may enter.
        if (res_cnt == 2'd3) begin
          px_sobel_o <= pack;
          px_rdy_o   <= 1'b1;
        end
        if (s2_valid) begin
          pack    <= {pack[WORD_W-PIXEL_W-1:0], s2_res};
          res_cnt <= (res_cnt == 2'd3) ? 2'd1 : res_cnt + 2'd1;
        end else if (res_cnt == 2'd3) begin
          res_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_column_engine.sv
// tb/tb_sobel_column_engine.sv - randomized and directed bench for sobel_column_engine
// Reference model works on whole columns per strip and schedules each packed word three edges after its last input.
module tb_sobel_column_engine;

  logic        clk_i = 1'b0;
  logic        nreset_i = 1'b0;
  logic [23:0] px_gray_i = '0;
  logic        px_rdy_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [23:0] px_sobel_o;
  logic        px_rdy_o;

  sobel_column_engine dut (
    .clk_i      (clk_i),
    .nreset_i   (nreset_i),
    .px_gray_i  (px_gray_i),
    .px_rdy_i   (px_rdy_i),
    .clear_i    (clear_i),
    .px_sobel_o (px_sobel_o),
    .px_rdy_o   (px_rdy_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int THR = 128;

  int total = 0;
  int bad = 0;

  int          cyc;
  logic [23:0] strip[$];
  logic [7:0]  part[$];
  int          pend_cyc[$];
  logic [23:0] pend_word[$];
  logic        exp_rdy;
  logic [23:0] exp_word;

  function automatic logic [7:0] ref_mag(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    int gx, gy, m;
    gx = (int'(c[23:16]) + 2 * int'(c[15:8]) + int'(c[7:0]))
       - (int'(a[23:16]) + 2 * int'(a[15:8]) + int'(a[7:0]));
    gy = (int'(a[7:0]) + 2 * int'(b[7:0]) + int'(c[7:0]))
       - (int'(a[23:16]) + 2 * int'(b[23:16]) + int'(c[23:16]));
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
    return (m >= THR) ? 8'hFF : 8'h00;
`else
    return (m > 255) ? 8'hFF : m[7:0];
`endif
  endfunction

  function automatic void model_reset();
    cyc = 0;
    strip.delete();
    part.delete();
    pend_cyc.delete();
    pend_word.delete();
    exp_rdy = 1'b0;
    exp_word = '0;
  endfunction

  // Drives one cycle of inputs, advances the model, leaves the bench at the following negedge.
  task automatic step(input logic [23:0] col, input logic rdy, input logic clr);
    px_gray_i = col;
    px_rdy_i = rdy;
    clear_i = clr;
    @(posedge clk_i);
    cyc++;
    if (clr) begin
      strip.delete();
      part.delete();
      pend_cyc.delete();
      pend_word.delete();
    end
    if (rdy) begin
      strip.push_back(col);
      if (strip.size() > 3) void'(strip.pop_front());
      if (strip.size() == 3) begin
        part.push_back(ref_mag(strip[0], strip[1], strip[2]));
        if (part.size() == 3) begin
          pend_cyc.push_back(cyc + 3);
          pend_word.push_back({part[0], part[1], part[2]});
          part.delete();
        end
      end
    end
    exp_rdy = 1'b0;
    if (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
      exp_rdy = 1'b1;
      exp_word = pend_word.pop_front();
      void'(pend_cyc.pop_front());
    end
    @(negedge clk_i);
    px_rdy_i = 1'b0;
    clear_i = 1'b0;
    px_gray_i = 24'($urandom);
  endtask

  task automatic test_reset();
    nreset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    total++;
    if (px_sobel_o !== 24'h0 || px_rdy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: rdy=%b word=%h want rdy=0 word=000000", px_rdy_o, px_sobel_o);
    end
    nreset_i = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(24'($urandom), 1'b0, 1'b0);
      total++;
      if (px_rdy_o !== 1'b0 || px_sobel_o !== 24'h0) begin
        bad++;
        $display("FAIL reset_idle: cyc=%0d rdy=%b word=%h want rdy=0 word=000000", i, px_rdy_o, px_sobel_o);
      end
    end
  endtask

  task automatic run_directed(input string name, input logic [23:0] cols[$], input int want_pulses, input logic [23:0] want_word);
    int pulses = 0;
    for (int i = 0; i < cols.size() + 6; i++) begin
      if (i < cols.size()) step(cols[i], 1'b1, 1'b0);
      else step(24'($urandom), 1'b0, 1'b0);
      if (px_rdy_o === 1'b1) pulses++;
      total++;
      if (px_rdy_o !== exp_rdy || px_sobel_o !== exp_word) begin
        bad++;
        $display("FAIL %s_model: cyc=%0d rdy=%b word=%h want rdy=%b word=%h", name, i, px_rdy_o, px_sobel_o, exp_rdy, exp_word);
      end
    end
    total++;
    if (pulses != want_pulses || px_sobel_o !== want_word) begin
      bad++;
      $display("FAIL %s_result: pulses=%0d word=%h want pulses=%0d word=%h", name, pulses, px_sobel_o, want_pulses, want_word);
    end
  endtask

  task automatic test_flat();
    logic [23:0] cols[$];
    cols = '{24'h505050, 24'h505050, 24'h505050, 24'h505050, 24'h505050};
    step('0, 1'b0, 1'b1);
    run_directed("flat", cols, 1, 24'h000000);
  endtask

  task automatic test_vertical();
    logic [23:0] cols[$];
    cols = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    step('0, 1'b0, 1'b1);
    run_directed("vertical", cols, 1, 24'hFFFF00);
  endtask

  task automatic test_horizontal();
    logic [23:0] cols[$];
    cols = '{24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0000FF};
    step('0, 1'b0, 1'b1);
    run_directed("horizontal", cols, 1, 24'hFFFFFF);
  endtask

  task automatic test_clear();
    logic [23:0] cols[$];
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(24'h000000, 1'b1, 1'b0);
      total++;
      if (px_rdy_o !== 1'b0) begin
        bad++;
        $display("FAIL clear_pre: cyc=%0d rdy=%b want 0", i, px_rdy_o);
      end
    end
    step('0, 1'b0, 1'b1);
    total++;
    if (px_rdy_o !== 1'b0) begin
      bad++;
      $display("FAIL clear_edge: rdy=%b want 0", px_rdy_o);
    end
    cols = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    run_directed("clear", cols, 1, 24'hFFFF00);
  endtask

  task automatic test_back_to_back();
    int pulse_at[$];
    step('0, 1'b0, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      if (i <= 9) step(24'h0000FF, 1'b1, 1'b0);
      else step(24'($urandom), 1'b0, 1'b0);
      if (px_rdy_o === 1'b1) pulse_at.push_back(i);
      total++;
      if (px_rdy_o !== exp_rdy || px_sobel_o !== exp_word) begin
        bad++;
        $display("FAIL b2b_model: step=%0d rdy=%b word=%h want rdy=%b word=%h", i, px_rdy_o, px_sobel_o, exp_rdy, exp_word);
      end
      if (px_rdy_o === 1'b1) begin
        total++;
        if (px_sobel_o !== 24'hFFFFFF) begin
          bad++;
          $display("FAIL b2b_word: step=%0d word=%h want FFFFFF", i, px_sobel_o);
        end
      end
    end
    total++;
    if (pulse_at.size() != 2 || pulse_at[0] != 8 || pulse_at[1] != 11) begin
      bad++;
      $display("FAIL b2b_timing: pulses=%0d first=%0d want 2 pulses at steps 8 and 11",
               pulse_at.size(), pulse_at.size() > 0 ? pulse_at[0] : -1);
    end
  endtask

  task automatic test_clear_with_strobe();
    logic [23:0] cols[$];
    step('0, 1'b0, 1'b1);
    step(24'hFFFFFF, 1'b1, 1'b0);
    step(24'hFFFFFF, 1'b1, 1'b0);
    step(24'h000000, 1'b1, 1'b1);
    cols = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    run_directed("clear_strobe", cols, 1, 24'hFFFF00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [23:0] col;
      case ($urandom_range(0, 3))
        0: col = 24'($urandom);
        1: col = {$urandom_range(0, 1) ? 8'hFF : 8'h00, $urandom_range(0, 1) ? 8'hFF : 8'h00, $urandom_range(0, 1) ? 8'hFF : 8'h00};
        2: col = {8'($urandom_range(100, 140)), 8'($urandom_range(100, 140)), 8'($urandom_range(100, 140))};
        default: col = 24'($urandom) & 24'h3F3F3F;
      endcase
      step(col, $urandom_range(0, 4) != 0, $urandom_range(0, 40) == 0);
      total++;
      if (px_rdy_o !== exp_rdy || px_sobel_o !== exp_word) begin
        bad++;
        $display("FAIL random: step=%0d rdy=%b word=%h want rdy=%b word=%h", i, px_rdy_o, px_sobel_o, exp_rdy, exp_word);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) step(24'h0000FF, 1'b1, 1'b0);
    #2 nreset_i = 1'b0;
    #1;
    total++;
    if (px_rdy_o !== 1'b0 || px_sobel_o !== 24'h0) begin
      bad++;
      $display("FAIL async_reset: rdy=%b word=%h want rdy=0 word=000000", px_rdy_o, px_sobel_o);
    end
    @(negedge clk_i);
    nreset_i = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step(24'($urandom), 1'b0, 1'b0);
      total++;
      if (px_rdy_o !== 1'b0 || px_sobel_o !== 24'h0) begin
        bad++;
        $display("FAIL async_reset_after: cyc=%0d rdy=%b word=%h want rdy=0 word=000000", i, px_rdy_o, px_sobel_o);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_flat();
    test_vertical();
    test_horizontal();
    test_clear();
    test_back_to_back();
    test_clear_with_strobe();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
